// File: rtl/debouncer_multi_fsm.sv
// debouncer_multi_fsm: N independent pushbutton/switch debouncers.
// Each channel has its own four-state qualification FSM and stability counter.
// A level change is accepted only after it has been sampled DELAY+1 times in a row.
// debounced, rise, fall and busy are all registered.
// Optional build macro DEBOUNCER_SYNC_EN puts a 2-flop synchronizer in front of
// every channel, which adds two cycles of latency.
// Without the macro, noisy is assumed to be synchronous to clk already.
module debouncer_multi_fsm #(
    parameter int N     = 4,
    parameter int DELAY = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] noisy,
    output logic [N-1:0] debounced,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         busy
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ARM_HI = 2'b01;
    localparam logic [1:0] ST_HIGH   = 2'b11;
    localparam logic [1:0] ST_ARM_LO = 2'b10;

    // Sampled input seen by the FSMs
    logic [N-1:0] s;

`ifdef DEBOUNCER_SYNC_EN
    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;

    // Synchronizer next-state: shift the raw pins through two stages
    always_comb begin
        sync1_d = noisy;
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer, cleared on reset so no stale level leaks out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = noisy;
`endif

    logic [1:0]       state_q [N];
    logic [1:0]       state_d [N];
    logic [CNT_W-1:0] cnt_q   [N];
    logic [CNT_W-1:0] cnt_d   [N];

    logic [N-1:0] debounced_q, debounced_d;
    logic [N-1:0] rise_q, rise_d;
    logic [N-1:0] fall_q, fall_d;
    logic         busy_q, busy_d;

    // Per-channel next state and counter.
    // Outputs are decoded from the *next* state so that the registered copies line up
    // with the state register, with no extra cycle of latency.
    always_comb begin
        debounced_d = '0;
        rise_d      = '0;
        fall_d      = '0;
        busy_d      = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                ST_IDLE: begin
                    if (s[i]) begin
                        state_d[i] = ST_ARM_HI;
                    end
                end
                ST_ARM_HI: begin
                    if (!s[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_HIGH;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!s[i]) begin
                        state_d[i] = ST_ARM_LO;
                    end
                end
                ST_ARM_LO: begin
                    if (s[i]) begin
                        state_d[i] = ST_HIGH;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            debounced_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_ARM_LO);
            rise_d[i]      = (state_q[i] == ST_ARM_HI) && (state_d[i] == ST_HIGH);
            fall_d[i]      = (state_q[i] == ST_ARM_LO) && (state_d[i] == ST_IDLE);
            busy_d         = busy_d
                           | (state_d[i] == ST_ARM_HI)
                           | (state_d[i] == ST_ARM_LO);
        end
    end

    // State, counters and registered outputs; asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            debounced_q <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            debounced_q <= debounced_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            busy_q      <= busy_d;
        end
    end

    assign debounced = debounced_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_debouncer_multi_fsm.sv
// Testbench for debouncer_multi_fsm.
// Two instances are exercised: the default configuration (N=4, DELAY=8) and a
// minimal one (N=2, DELAY=1).
// The reference model tracks, for each channel, the accepted level and the length of
// the current run of samples that disagree with it. A run of DELAY+1 such samples
// flips the level.
module tb_debouncer_multi_fsm;

    localparam int N0 = 4;
    localparam int D0 = 8;
    localparam int N1 = 2;
    localparam int D1 = 1;
`ifdef DEBOUNCER_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] noisy0, deb0, rise0, fall0;
    logic       busy0;
    logic [1:0] noisy1, deb1, rise1, fall1;
    logic       busy1;

    debouncer_multi_fsm #(.N(N0), .DELAY(D0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .noisy(noisy0),
        .debounced(deb0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debouncer_multi_fsm #(.N(N1), .DELAY(D1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .noisy(noisy1),
        .debounced(deb1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_lvl [2][4];
    int unsigned m_run [2][4];
    logic [3:0]  m_p1 [2];
    logic [3:0]  m_p2 [2];
    logic [3:0]  e_deb [2];
    logic [3:0]  e_rise [2];
    logic [3:0]  e_fall [2];
    logic        e_busy [2];

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_lvl[d][c] = 1'b0;
                m_run[d][c] = 0;
            end
            m_p1[d]   = '0;
            m_p2[d]   = '0;
            e_deb[d]  = '0;
            e_rise[d] = '0;
            e_fall[d] = '0;
            e_busy[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int unsigned dly;
        int unsigned nch;
        logic [3:0]  raw;
        logic [3:0]  s;
        if (!reset_n) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            dly = (d == 0) ? D0 : D1;
            nch = (d == 0) ? N0 : N1;
            raw = (d == 0) ? noisy0 : {2'b00, noisy1};
            if (SYNC_LAT != 0) begin
                s = m_p2[d];
                m_p2[d] = m_p1[d];
                m_p1[d] = raw;
            end else begin
                s = raw;
            end
            e_rise[d] = '0;
            e_fall[d] = '0;
            e_busy[d] = 1'b0;
            e_deb[d]  = '0;
            for (int c = 0; c < nch; c++) begin
                if (s[c] != m_lvl[d][c]) begin
                    m_run[d][c]++;
                    if (m_run[d][c] == dly + 1) begin
                        m_lvl[d][c] = s[c];
                        m_run[d][c] = 0;
                        if (s[c]) e_rise[d][c] = 1'b1;
                        else      e_fall[d][c] = 1'b1;
                    end
                end else begin
                    m_run[d][c] = 0;
                end
                e_deb[d][c] = m_lvl[d][c];
                if (m_run[d][c] != 0) e_busy[d] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        check("m_deb0",  deb0,  e_deb[0]);
        check("m_rise0", rise0, e_rise[0]);
        check("m_fall0", fall0, e_fall[0]);
        check("m_busy0", busy0, e_busy[0]);
        check("m_deb1",  deb1,  e_deb[1][1:0]);
        check("m_rise1", rise1, e_rise[1][1:0]);
        check("m_fall1", fall1, e_fall[1][1:0]);
        check("m_busy1", busy1, e_busy[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic reset_assert();
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        #1;
        compare_model();
        check("rst_now_deb",  deb0,  4'h0);
        check("rst_now_rise", rise0, 4'h0);
        check("rst_now_busy", busy0, 1'b0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] nz;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] nz, input logic [3:0] deb, input logic [3:0] ri,
                       input logic [3:0] fa, input logic bz, input int unsigned rep);
        vec_t v;
        v.nz = nz; v.deb = deb; v.rise = ri; v.fall = fa; v.busy = bz;
        for (int unsigned k = 0; k < rep; k++) tbl.push_back(v);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nrows;
        int unsigned r;
        int unsigned first;
        vec_t        v;

        // ch0 clean press, ch1 bounces 1,0,1,1,0 then holds 1
        add(4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1);
        add(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1);
        add(4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 2);
        add(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1);
        add(4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 3);
        add(4'h3, 4'h1, 4'h1, 4'h0, 1'b1, 1);
        add(4'h3, 4'h1, 4'h0, 4'h0, 1'b1, 4);
        add(4'h3, 4'h3, 4'h2, 4'h0, 1'b0, 1);
        add(4'h3, 4'h3, 4'h0, 4'h0, 1'b0, 1);
        // ch0 release glitch: 7 low samples then high again, no fall
        add(4'h2, 4'h3, 4'h0, 4'h0, 1'b1, 7);
        add(4'h3, 4'h3, 4'h0, 4'h0, 1'b0, 1);
        // ch0 real release
        add(4'h2, 4'h3, 4'h0, 4'h0, 1'b1, 8);
        add(4'h2, 4'h2, 4'h0, 4'h1, 1'b0, 1);
        add(4'h2, 4'h2, 4'h0, 4'h0, 1'b0, 1);
        // ch0 rises while ch1 falls on the same cycle
        add(4'h1, 4'h2, 4'h0, 4'h0, 1'b1, 8);
        add(4'h1, 4'h1, 4'h1, 4'h2, 1'b0, 1);
        add(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 1);

        noisy0  = '0;
        noisy1  = '0;
        reset_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        reset_release();
        repeat (4 + SYNC_LAT) step();

        nrows = tbl.size();
        for (int unsigned j = 0; j < nrows + SYNC_LAT; j++) begin
            r = (j < nrows) ? j : nrows - 1;
            noisy0 = tbl[r].nz;
            step();
            if (j >= SYNC_LAT) begin
                v = tbl[j - SYNC_LAT];
                check("tbl_deb",  deb0,  v.deb);
                check("tbl_rise", rise0, v.rise);
                check("tbl_fall", fall0, v.fall);
                check("tbl_busy", busy0, v.busy);
            end
        end

        // Reset held with all inputs high, then release
        noisy0 = 4'hF;
        noisy1 = 2'b00;
        reset_assert();
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_hold_deb",  deb0,  4'h0);
            check("rst_hold_rise", rise0, 4'h0);
            check("rst_hold_busy", busy0, 1'b0);
        end
        reset_release();
        first = D0 + 1 + SYNC_LAT;
        for (int unsigned e = 1; e <= D0 + 3 + SYNC_LAT; e++) begin
            step();
            check("rel_deb",  deb0,  (e >= first) ? 4'hF : 4'h0);
            check("rel_rise", rise0, (e == first) ? 4'hF : 4'h0);
            check("rel_busy", busy0, (e >= 1 + SYNC_LAT) && (e < first));
        end

        noisy0 = 4'h0;
        repeat (D0 + 4 + SYNC_LAT) step();
        check("all_low", deb0, 4'h0);

        // Reset while ch0 is mid-qualification: no strobe afterwards
        noisy0 = 4'h1;
        repeat (3 + SYNC_LAT) step();
        check("arm_busy", busy0, 1'b1);
        check("arm_deb",  deb0,  4'h0);
        reset_assert();
        noisy0 = 4'h0;
        repeat (2) step();
        reset_release();
        for (int k = 0; k < D0 + 4; k++) begin
            step();
            check("mid_rise", rise0, 4'h0);
            check("mid_fall", fall0, 4'h0);
            check("mid_deb",  deb0,  4'h0);
        end

        // DELAY=1 instance: held input qualifies after two samples
        noisy1 = 2'b01;
        first  = 2 + SYNC_LAT;
        for (int unsigned e = 1; e <= 4 + SYNC_LAT; e++) begin
            step();
            check("d1_deb",  deb1[0],  e >= first);
            check("d1_rise", rise1[0], e == first);
        end
        // A single-sample pulse must not qualify
        noisy1 = 2'b11;
        step();
        noisy1 = 2'b01;
        repeat (4 + SYNC_LAT) step();
        check("d1_pulse", deb1, 2'b01);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 4) == 0) noisy0[c] = ~noisy0[c];
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 2) == 0) noisy1[c] = ~noisy1[c];
            if ($urandom_range(0, 399) == 0) begin
                reset_assert();
                step();
                reset_release();
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
